song_recorder: RTL and testbench

- Writer-side counterpart of song_reader_v2: captures notes played live on a keypad and writes them to song RAM in the {note, duration} format the reader consumes.
- Sits beside mcu and song_reader_v2 and shares the beat input from beat_gen_ff_enabled.
- Measures each held note or rest in beats and commits one entry per change.
- Closes every recording with an end marker.

---
 rtl/music_defs_pkg.sv | 31 +++
 rtl/song_recorder_beat_dur_counter.sv | 30 +++
 rtl/song_recorder.sv | 149 ++++++++++++++
 tb/tb_song_recorder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_defs_pkg.sv
// Shared song-RAM definitions used by the recorder and the reader side.
// Entries are packed {note, duration}; an all-zero word terminates a song.
package music_defs;

    localparam int NOTE_WIDTH = 6;
    localparam int DUR_WIDTH  = 6;

    localparam logic [NOTE_WIDTH-1:0]           REST_NOTE  = '0;
    localparam logic [NOTE_WIDTH+DUR_WIDTH-1:0] END_MARKER = '0;

    typedef struct packed {
        logic [NOTE_WIDTH-1:0] note;
        logic [DUR_WIDTH-1:0]  dur;
    } song_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECORD,
        ST_TERMINATE
    } rec_state_t;

    function automatic song_entry_t pack_entry(input logic [NOTE_WIDTH-1:0] note,
                                               input logic [DUR_WIDTH-1:0]  dur);
        song_entry_t e;
        e.note = note;
        e.dur  = dur;
        return e;
    endfunction

endpackage

// File: rtl/song_recorder_beat_dur_counter.sv
// Saturating beat counter measuring how long the current note or rest has lasted.
// Priority: clear, then load-1, then count.
module beat_dur_counter #(
    parameter int DUR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_one,
    input  logic                 count_en,
    output logic [DUR_WIDTH-1:0] dur,
    output logic                 sat
);

    localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;
    localparam logic [DUR_WIDTH-1:0] DUR_ONE = DUR_WIDTH'(1);

    assign sat = (dur == DUR_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dur <= '0;
        end else if (load_one) begin
            dur <= DUR_ONE;
        end else if (count_en && !sat) begin
            dur <= dur + DUR_ONE;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Live keypad recorder: measures each held note or rest in beats and writes
// {note, duration} entries to song RAM, closing every recording with an end marker.
//
// state        | meaning
// -------------|-------------------------------------------------------------
// ST_IDLE      | waiting for record_button
// ST_ARMED     | recording, leading silence skipped until the first key
// ST_RECORD    | timing cur_note; commits an entry on every change
// ST_TERMINATE | one cycle; end marker is written and song_length latched
module song_recorder #(
    parameter int ADDR_WIDTH = 7,
    parameter int NOTE_WIDTH = music_defs::NOTE_WIDTH,
    parameter int DUR_WIDTH  = music_defs::DUR_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            record_button,
    input  logic                            beat,
    input  logic [NOTE_WIDTH-1:0]           key_note,
    input  logic                            key_valid,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [NOTE_WIDTH+DUR_WIDTH-1:0] wr_data,
    output logic                            recording,
    output logic [ADDR_WIDTH-1:0]           song_length,
    output logic                            full
);

    import music_defs::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CAP_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
    localparam logic [DUR_WIDTH-1:0]  DUR_ONE  = DUR_WIDTH'(1);

    rec_state_t state, state_next;

    logic [NOTE_WIDTH-1:0] obs, cur_note, note_next;
    logic [DUR_WIDTH-1:0]  dur, dur_credit;
    logic                  dur_sat;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  cnt_clear, cnt_load_one, cnt_en;
    logic                  commit, start, full_set;

    beat_dur_counter #(.DUR_WIDTH(DUR_WIDTH)) u_dur (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .count_en (cnt_en),
        .dur      (dur),
        .sat      (dur_sat)
    );

    assign obs = key_valid ? key_note : REST_NOTE;

    // A beat landing on the same cycle as a change belongs to the outgoing entry.
    assign dur_credit = (beat && !dur_sat) ? dur + DUR_ONE : dur;

    assign recording = (state == ST_ARMED) || (state == ST_RECORD);

    always_comb begin
        state_next   = state;
        note_next    = cur_note;
        commit       = 1'b0;
        start        = 1'b0;
        full_set     = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load_one = 1'b0;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (record_button) begin
                    start      = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                cnt_clear = 1'b1;
                if (record_button) begin
                    state_next = ST_TERMINATE;
                end else if (obs != REST_NOTE) begin
                    note_next  = obs;
                    state_next = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (record_button) begin
                    commit     = (dur_credit != '0) && (cur_note != REST_NOTE);
                    state_next = ST_TERMINATE;
                end else if (obs != cur_note) begin
                    note_next = obs;
                    cnt_clear = 1'b1;
                    commit    = (dur_credit != '0);
                end else if (beat && dur_sat) begin
                    commit       = 1'b1;
                    cnt_load_one = 1'b1;
                end else begin
                    cnt_en = beat;
                end
                // Only the terminator slot left: stop taking keys.
                if (commit && !record_button && addr_cnt == CAP_ADDR) begin
                    full_set   = 1'b1;
                    state_next = ST_TERMINATE;
                end
            end
            ST_TERMINATE: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_note    <= REST_NOTE;
            addr_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            song_length <= '0;
            full        <= 1'b0;
        end else begin
            state    <= state_next;
            cur_note <= note_next;
            wr_en    <= 1'b0;
            if (start) begin
                addr_cnt    <= '0;
                song_length <= '0;
                full        <= 1'b0;
            end
            if (commit) begin
                wr_en    <= 1'b1;
                wr_addr  <= addr_cnt;
                wr_data  <= {cur_note, dur_credit};
                addr_cnt <= addr_cnt + ADDR_ONE;
            end
            if (full_set) begin
                full <= 1'b1;
            end
            if (state == ST_TERMINATE) begin
                wr_en       <= 1'b1;
                wr_addr     <= addr_cnt;
                wr_data     <= END_MARKER;
                song_length <= addr_cnt;
            end
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: scoreboarded song scenarios on a full-size and a
// 4-entry instance, plus a cycle table for coincident beat/change/record events.
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset, button, beat, key_valid, sel, sb_en;
    logic [5:0]  key_note;
    logic        btn0, btn1;

    logic        wr_en0, recording0, full0;
    logic [6:0]  wr_addr0, song_length0;
    logic [11:0] wr_data0;
    logic        wr_en1, recording1, full1;
    logic [1:0]  wr_addr1, song_length1;
    logic [11:0] wr_data1;

    assign btn0 = button & ~sel;
    assign btn1 = button & sel;

    song_recorder dut0 (
        .clk(clk), .reset(reset), .record_button(btn0), .beat(beat),
        .key_note(key_note), .key_valid(key_valid), .wr_en(wr_en0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .recording(recording0),
        .song_length(song_length0), .full(full0)
    );

    song_recorder #(.ADDR_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset), .record_button(btn1), .beat(beat),
        .key_note(key_note), .key_valid(key_valid), .wr_en(wr_en1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .recording(recording1),
        .song_length(song_length1), .full(full1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]  addr;
        logic [11:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;

    typedef struct {
        logic        btn;
        logic        bt;
        logic        kv;
        logic [5:0]  kn;
        logic        e_we;
        logic [6:0]  e_addr;
        logic [11:0] e_data;
        logic        e_rec;
    } step_t;

    step_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ent(input logic [5:0] n, input logic [5:0] d);
        return {n, d};
    endfunction

    task automatic push0(input logic [6:0] a, input logic [11:0] d);
        q0.push_back('{addr: a, data: d});
    endtask

    task automatic push1(input logic [6:0] a, input logic [11:0] d);
        q1.push_back('{addr: a, data: d});
    endtask

    task automatic cyc(input logic b, input logic bt, input logic kv, input logic [5:0] kn);
        @(negedge clk);
        button    = b;
        beat      = bt;
        key_valid = kv;
        key_note  = kn;
        @(posedge clk);
        #1;
    endtask

    // One cycle to present the key, then n beats each followed by a quiet cycle.
    task automatic hold(input logic kv, input logic [5:0] kn, input int n);
        cyc(1'b0, 1'b0, kv, kn);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, kv, kn);
            cyc(1'b0, 1'b0, kv, kn);
        end
    endtask

    task automatic drain(input string name);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 6'd0);
        chk({name, " dut0 missing writes"}, 32'(q0.size()), 32'd0);
        chk({name, " dut1 missing writes"}, 32'(q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            if (wr_en0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut0 write actual=addr %0h data %0h required=no write", wr_addr0, wr_data0);
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0 wr_addr", 32'(wr_addr0), 32'(e0.addr));
                    chk("dut0 wr_data", 32'(wr_data0), 32'(e0.data));
                end
            end
            if (wr_en1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1 write actual=addr %0h data %0h required=no write", wr_addr1, wr_data1);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1 wr_addr", 32'(wr_addr1), 32'(e1.addr));
                    chk("dut1 wr_data", 32'(wr_data1), 32'(e1.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_zero(input string name);
        chk({name, " wr_en"},       32'(wr_en0),       32'd0);
        chk({name, " wr_addr"},     32'(wr_addr0),     32'd0);
        chk({name, " wr_data"},     32'(wr_data0),     32'd0);
        chk({name, " recording"},   32'(recording0),   32'd0);
        chk({name, " song_length"}, 32'(song_length0), 32'd0);
        chk({name, " full"},        32'(full0),        32'd0);
    endtask

    initial begin
        reset = 1'b1; button = 1'b0; beat = 1'b0; key_valid = 1'b0;
        key_note = 6'd0; sel = 1'b0; sb_en = 1'b0;

        //                 btn   beat  kv    note   we    addr   data          rec
        tbl[0] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 12'h000,      1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 7'd0, 12'h000,      1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 6'd7, 1'b0, 7'd0, 12'h000,      1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 6'd8, 1'b1, 7'd0, ent(6'd7, 6'd2), 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 7'd0, 12'h000,      1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 6'd8, 1'b0, 7'd0, 12'h000,      1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 6'd8, 1'b1, 7'd1, ent(6'd8, 6'd2), 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 7'd2, 12'h000,      1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 7'd0, 12'h000,      1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        sb_en = 1'b1;

        // Basic song
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        chk("basic armed recording", 32'(recording0), 32'd1);
        hold(1'b1, 6'd20, 3);
        push0(7'd0, ent(6'd20, 6'd3));
        hold(1'b0, 6'd0, 2);
        push0(7'd1, ent(6'd0, 6'd2));
        hold(1'b1, 6'd30, 1);
        push0(7'd2, ent(6'd30, 6'd1));
        push0(7'd3, 12'h000);
        cyc(1'b1, 1'b0, 1'b1, 6'd30);
        chk("basic recording falls", 32'(recording0), 32'd0);
        drain("basic");
        chk("basic song_length", 32'(song_length0), 32'd3);
        chk("basic full", 32'(full0), 32'd0);

        // Saturation at 63 beats
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        push0(7'd0, ent(6'd5, 6'd63));
        hold(1'b1, 6'd5, 70);
        push0(7'd1, ent(6'd5, 6'd7));
        cyc(1'b0, 1'b0, 1'b0, 6'd0);
        push0(7'd2, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        drain("saturation");
        chk("saturation song_length", 32'(song_length0), 32'd2);

        // Glitch filter and leading silence
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        hold(1'b0, 6'd0, 4);
        hold(1'b1, 6'd12, 0);
        hold(1'b1, 6'd13, 2);
        push0(7'd0, ent(6'd13, 6'd2));
        push0(7'd1, 12'h000);
        cyc(1'b1, 1'b0, 1'b1, 6'd13);
        drain("glitch");
        chk("glitch song_length", 32'(song_length0), 32'd1);

        // Capacity on the 4-entry instance
        sel = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        hold(1'b1, 6'd1, 1);
        push1(7'd0, ent(6'd1, 6'd1));
        hold(1'b1, 6'd2, 1);
        push1(7'd1, ent(6'd2, 6'd1));
        hold(1'b1, 6'd3, 1);
        push1(7'd2, ent(6'd3, 6'd1));
        push1(7'd3, 12'h000);
        hold(1'b1, 6'd4, 1);
        drain("capacity");
        chk("capacity full", 32'(full1), 32'd1);
        chk("capacity song_length", 32'(song_length1), 32'd3);
        chk("capacity recording", 32'(recording1), 32'd0);
        sel = 1'b0;

        // Empty song
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0);
        push0(7'd0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        drain("empty");
        chk("empty song_length", 32'(song_length0), 32'd0);
        chk("empty recording", 32'(recording0), 32'd0);

        // Coincident beat / change / record, checked cycle by cycle
        sb_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            button    = tbl[i].btn;
            beat      = tbl[i].bt;
            key_valid = tbl[i].kv;
            key_note  = tbl[i].kn;
            @(posedge clk);
            #1;
            chk($sformatf("table[%0d] wr_en", i), 32'(wr_en0), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("table[%0d] wr_addr", i), 32'(wr_addr0), 32'(tbl[i].e_addr));
                chk($sformatf("table[%0d] wr_data", i), 32'(wr_data0), 32'(tbl[i].e_data));
            end
            chk($sformatf("table[%0d] recording", i), 32'(recording0), 32'(tbl[i].e_rec));
        end
        sb_en = 1'b1;
        chk("table song_length", 32'(song_length0), 32'd2);

        // Reset in the middle of RECORD, on a cycle that would otherwise commit
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        hold(1'b1, 6'd9, 2);
        @(negedge clk);
        reset     = 1'b1;
        key_valid = 1'b0;
        beat      = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        chk("midreset dut1 full", 32'(full1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'(i % 2), 1'b1, 6'(3 + i));
        end
        drain("midreset");
        chk("midreset recording", 32'(recording0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
